// File: rtl/regfile_writeback_queue.sv
// In-order write-back FIFO in front of the 32 x 64 register file; retires one entry per cycle as a one-hot write enable.
// Optional forwarding search of queued entries is enabled by defining REGFILE_WBQ_FWD_EN.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wb_valid,
    output logic                           wb_ready,
    input  logic [ADDR_W-1:0]              wb_addr,
    input  logic [DATA_W-1:0]              wb_data,
    input  logic                           drain_hold,
    output logic [NREGS-1:0]               write_en,
    output logic [DATA_W-1:0]              DataIn,
    output logic [$clog2(DEPTH+1)-1:0]     count
`ifdef REGFILE_WBQ_FWD_EN
    ,
    input  logic [ADDR_W-1:0]              fwd_addr,
    output logic                           fwd_hit,
    output logic [DATA_W-1:0]              fwd_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] XZR     = ADDR_W'(NREGS - 1);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic             push;
    logic             pop;
    logic [ADDR_W-1:0] head_addr;

    // Readiness depends only on registered occupancy, never on wb_valid.
    assign wb_ready  = reset && (count_reg < DEPTH_C);
    // XZR requests complete the handshake but never occupy an entry.
    assign push      = wb_valid && wb_ready && (wb_addr != XZR);
    assign pop       = reset && (count_reg != '0) && !drain_hold;
    assign head_addr = addr_mem[rd_ptr_reg];

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= wb_addr;
            data_mem[wr_ptr_reg] <= wb_data;
        end
    end

    // Decoder gated by pop guarantees at most one enable bit.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_we_decode
        assign write_en[gi] = pop && (head_addr == ADDR_W'(gi));
    end

    assign DataIn = pop ? data_mem[rd_ptr_reg] : '0;
    assign count  = reset ? count_reg : '0;

`ifdef REGFILE_WBQ_FWD_EN
    logic [DEPTH-1:0] fwd_match;

    // fwd_match is indexed by age: bit 0 is the head, higher bits are newer.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd_match
        assign fwd_match[gi] = (CNT_W'(gi) < count_reg) &&
                               (addr_mem[rd_ptr_reg + PTR_W'(gi)] == fwd_addr);
    end

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (reset && (fwd_addr != XZR)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fwd_match[i]) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_mem[rd_ptr_reg + PTR_W'(i)];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench for regfile_writeback_queue; checks every output each cycle on the falling edge.
module tb_regfile_writeback_queue;

    typedef struct packed {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        drain_hold;
    logic [31:0] write_en;
    logic [63:0] DataIn;
    logic [2:0]  count;
`ifdef REGFILE_WBQ_FWD_EN
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [63:0] fwd_data;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t sb[$];

    regfile_writeback_queue #(.DEPTH(4), .DATA_W(64), .ADDR_W(5), .NREGS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .drain_hold (drain_hold),
        .write_en   (write_en),
        .DataIn     (DataIn),
        .count      (count)
`ifdef REGFILE_WBQ_FWD_EN
        ,
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Compare all outputs against the scoreboard, then apply the coming edge to it.
    always @(negedge clk) begin
        logic [31:0] exp_we;
        logic [63:0] exp_d;
        logic        acc;
        exp_we = '0;
        exp_d  = '0;
        if (reset && sb.size() > 0 && !drain_hold) begin
            exp_we = 32'd1 << sb[0].a;
            exp_d  = sb[0].d;
        end
        check_eq("wb_ready", wb_ready, (reset && sb.size() < 4) ? 1 : 0);
        check_eq("count", count, reset ? sb.size() : 0);
        check_eq("write_en", write_en, exp_we);
        check_eq("DataIn", DataIn, exp_d);
        if (write_en != 0) $display("retire we=%08h data=%0d count=%0d", write_en, DataIn, count);
`ifdef REGFILE_WBQ_FWD_EN
        begin
            logic        eh;
            logic [63:0] ed;
            eh = 1'b0;
            ed = '0;
            if (reset && fwd_addr != 5'd31) begin
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (!eh && sb[i].a == fwd_addr) begin
                        eh = 1'b1;
                        ed = sb[i].d;
                    end
                end
            end
            check_eq("fwd_hit", fwd_hit, eh);
            check_eq("fwd_data", fwd_data, ed);
        end
`endif
        if (!reset) begin
            sb.delete();
        end else begin
            acc = wb_valid && (sb.size() < 4) && (wb_addr != 5'd31);
            if (sb.size() > 0 && !drain_hold) void'(sb.pop_front());
            if (acc) sb.push_back('{a: wb_addr, d: wb_data});
        end
    end

    task automatic drive(input logic v, input logic [4:0] a, input logic [63:0] d, input logic h);
        wb_valid   = v;
        wb_addr    = a;
        wb_data    = d;
        drain_hold = h;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        wb_valid   = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        drain_hold = 1'b0;
`ifdef REGFILE_WBQ_FWD_EN
        fwd_addr   = 5'd0;
`endif
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0);
        check_eq("reset_count", count, 0);
        check_eq("reset_ready", wb_ready, 0);
        reset = 1'b1;

        // Single write
        drive(1, 5, 64'd1348, 0);
        check_eq("single_we", write_en, 32'h0000_0020);
        check_eq("single_data", DataIn, 64'd1348);
        check_eq("single_count", count, 1);
        drive(0, 0, 0, 0);
        check_eq("single_we_after", write_en, 0);
        check_eq("single_count_after", count, 0);

        // XZR discard
        for (int i = 0; i < 3; i++) drive(1, 31, 64'hFFFF, 0);
        check_eq("xzr_count", count, 0);

        // Fill and backpressure
        for (int i = 1; i <= 4; i++) drive(1, 5'(i), 64'(i * 10), 1);
        drive(1, 9, 64'd99, 1);
        check_eq("full_count", count, 4);
        check_eq("full_ready", wb_ready, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);

        // Simultaneous push/pop with pointer wrap
        for (int i = 0; i < 10; i++) drive(1, 5'(i), 64'(100 + i), 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // Same-address ordering
        drive(1, 7, 64'd45948, 1);
        drive(1, 7, 64'd1, 1);
`ifdef REGFILE_WBQ_FWD_EN
        fwd_addr = 5'd7;
        #1;
        check_eq("fwd_hit_7", fwd_hit, 1);
        check_eq("fwd_data_7", fwd_data, 64'd1);
`endif
        drive(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
`ifdef REGFILE_WBQ_FWD_EN
        fwd_addr = 5'd0;
`endif

        // Reset mid-operation
        for (int i = 0; i < 3; i++) drive(1, 5'(11 + i), 64'(500 + i), 1);
        check_eq("pre_reset_count", count, 3);
        reset = 1'b0;
        drive(0, 0, 0, 1);
        reset = 1'b1;
        #1;
        check_eq("post_reset_count", count, 0);
        check_eq("post_reset_ready", wb_ready, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
        check_eq("post_reset_we", write_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
